// File: rtl/wb_resp_pkg.sv
// wb_resp_pkg: register offsets, status bit positions and FSM state type for wb_resp_regs
package wb_resp_pkg;
  localparam logic [2:0] REG_ID      = 3'd0;
  localparam logic [2:0] REG_SCRATCH = 3'd1;
  localparam logic [2:0] REG_CYCLES  = 3'd2;
  localparam logic [2:0] REG_CTRL    = 3'd3;
  localparam logic [2:0] REG_FIFO    = 3'd4;
  localparam logic [2:0] REG_STATUS  = 3'd5;
  localparam logic [2:0] REG_GPIO    = 3'd6;
  localparam logic [2:0] REG_RSVD    = 3'd7;
  localparam int ST_EMPTY = 16;
  localparam int ST_FULL  = 17;
  localparam int ST_OVF   = 18;
  localparam int ST_UDF   = 19;
  localparam int WCW = 4;
  typedef enum logic [1:0] {IDLE, WAITS, ACK} state_t;
endpackage

// File: rtl/wb_resp_fifo.sv
// wb_resp_fifo: synchronous first-word-fall-through FIFO with clear priority
module wb_resp_fifo #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full
);
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] rp, wp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count[AW];
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push && !clr) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else begin
      rp <= rp + AW'(do_pop);
      wp <= wp + AW'(do_push);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/wb_resp_regs.sv
// wb_resp_regs: Wishbone classic responder with ID/scratch/cycles/ctrl/FIFO/status/GPIO registers
import wb_resp_pkg::*;
module wb_resp_regs #(
  parameter logic [11:0] BASE    = 12'h000,
  parameter int          WAIT    = 0,
  parameter int          FIFO_AW = 4,
  parameter logic [31:0] ID      = 32'h57425253
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic        stb_i,
  output logic        ack_o,
  output logic [31:0] gpio_o,
  output logic        irq_o
);
  state_t state, state_n;
  logic [WCW-1:0] wcnt;
  logic [14:0] adr_q, adr;
  logic [31:0] dat_q, wd;
  logic we_q, wr;
  logic go, sel, wen, ren;
  logic [2:0] off;
  logic [31:0] scratch, cycles, rdata, status, fifo_dout;
  logic irq_en, ovf, udf;
  logic push, pop, clr, empty, full;
  logic [FIFO_AW:0] count;
  assign adr = state == IDLE ? adr_i : adr_q;
  assign wd = state == IDLE ? dat_i : dat_q;
  assign wr = state == IDLE ? we_i : we_q;
  assign go = state_n == ACK;
  assign sel = adr[14:3] == BASE;
  assign off = adr[2:0];
  assign wen = go & sel & wr;
  assign ren = go & sel & ~wr;
  assign push = wen && off == REG_FIFO;
  assign pop = ren && off == REG_FIFO;
  assign clr = wen && off == REG_CTRL && wd[1];
  assign ack_o = state == ACK;
  always_comb
    state_n = (state == ACK || !stb_i) ? IDLE :
              ((state == IDLE && WAIT != 0) || (state == WAITS && wcnt != '0)) ? WAITS : ACK;
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
    wcnt <= state == IDLE ? WCW'(WAIT - 1) : wcnt - WCW'(1);
    if (state == IDLE) begin
      adr_q <= adr_i;
      dat_q <= dat_i;
      we_q <= we_i;
    end
  end
  wb_resp_fifo #(.DW(32), .AW(FIFO_AW)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .clr(clr), .din(wd),
    .dout(fifo_dout), .count(count), .empty(empty), .full(full)
  );
  always_comb begin
    status = '0;
    status[FIFO_AW:0] = count;
    status[ST_EMPTY] = empty;
    status[ST_FULL] = full;
    status[ST_OVF] = ovf;
    status[ST_UDF] = udf;
  end
  always_comb begin
    rdata = '0;
    if (sel)
      case (off)
        REG_ID:      rdata = ID;
        REG_SCRATCH: rdata = scratch;
        REG_CYCLES:  rdata = cycles;
        REG_CTRL:    rdata = {31'b0, irq_en};
        REG_FIFO:    rdata = empty ? '0 : fifo_dout;
        REG_STATUS:  rdata = status;
        REG_GPIO:    rdata = gpio_o;
        default:     rdata = '0;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dat_o <= '0;
      gpio_o <= '0;
      irq_o <= 1'b0;
      scratch <= '0;
      cycles <= '0;
      irq_en <= 1'b0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (go) dat_o <= wr ? '0 : rdata;
      scratch <= (wen && off == REG_SCRATCH) ? wd : scratch;
      gpio_o <= (wen && off == REG_GPIO) ? wd : gpio_o;
      irq_en <= (wen && off == REG_CTRL) ? wd[0] : irq_en;
      cycles <= (wen && off == REG_CYCLES) ? wd : cycles + 32'd1;
      ovf <= (ovf | (push & full)) & ~(wen && off == REG_STATUS && wd[ST_OVF]);
      udf <= (udf | (pop & empty)) & ~(wen && off == REG_STATUS && wd[ST_UDF]);
      irq_o <= irq_en & ~empty;
    end
  end
endmodule
